// File: rtl/omsp_irq_latency_tracker.sv
// rtl/omsp_irq_latency_tracker.sv - interrupt request-to-acceptance latency observer
//
// Purpose:
//   Passive observer beside the interrupt frontend. For every serviced
//   interrupt it measures the number of cycles from the first cycle a request
//   is seen to the cycle it is accepted. It also counts how many of those
//   cycles had interrupts masked (gie low). It keeps a running maximum, a
//   sticky deadline-miss flag and a sticky counter-saturation flag. It never
//   drives anything on the interrupt path.
//
// Ports:
//   mclk          in   system clock
//   puc_rst       in   asynchronous active-high reset
//   irq_in        in   level interrupt requests (bit NR_IRQ-1 = highest priority)
//   irq_acc       in   acceptance pulses from the frontend (one-hot expected)
//   gie           in   effective interrupt enable
//   stat_clr      in   single-cycle clear of max/sticky results
//   in_wait       out  a measurement is in progress
//   lat_valid     out  one-cycle pulse, last_* just updated
//   last_lat      out  latency of the most recent serviced request
//   last_masked   out  gie-low cycles within last_lat
//   last_src      out  index of the accepted line
//   max_lat       out  largest last_lat since reset/clear
//   max_src       out  source of max_lat
//   deadline_miss out  sticky, some latency exceeded DEADLINE
//   sat_flag      out  sticky, a counter saturated
//   drop_pulse    out  one-cycle pulse, request withdrawn before service

module omsp_irq_latency_tracker #(
    parameter int  NR_IRQ    = 16,
    parameter int  LAT_WIDTH = 16,
    parameter int  DEADLINE  = 1000,
    localparam int SRC_W     = (NR_IRQ > 1) ? $clog2(NR_IRQ) : 1
) (
    input  logic                 mclk,
    input  logic                 puc_rst,
    input  logic [NR_IRQ-1:0]    irq_in,
    input  logic [NR_IRQ-1:0]    irq_acc,
    input  logic                 gie,
    input  logic                 stat_clr,
    output logic                 in_wait,
    output logic                 lat_valid,
    output logic [LAT_WIDTH-1:0] last_lat,
    output logic [LAT_WIDTH-1:0] last_masked,
    output logic [SRC_W-1:0]     last_src,
    output logic [LAT_WIDTH-1:0] max_lat,
    output logic [SRC_W-1:0]     max_src,
    output logic                 deadline_miss,
    output logic                 sat_flag,
    output logic                 drop_pulse
);

    // Deadline comparison is done in a width that holds both the sample and
    // DEADLINE, so a DEADLINE beyond the counter range simply never fires.
    localparam int                   CW      = (LAT_WIDTH > 32) ? LAT_WIDTH : 32;
    localparam logic [CW-1:0]        DL_C    = CW'(DEADLINE);
    localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;
    localparam logic [LAT_WIDTH-1:0] LAT_ONE = LAT_WIDTH'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic [LAT_WIDTH-1:0] r_cnt;
    logic [LAT_WIDTH-1:0] r_mcnt;
    logic                 r_lat_valid;
    logic [LAT_WIDTH-1:0] r_last_lat;
    logic [LAT_WIDTH-1:0] r_last_masked;
    logic [SRC_W-1:0]     r_last_src;
    logic [LAT_WIDTH-1:0] r_max_lat;
    logic [SRC_W-1:0]     r_max_src;
    logic                 r_deadline_miss;
    logic                 r_sat_flag;
    logic                 r_drop_pulse;

    logic                 w_pend;
    logic                 w_acc;
    logic [SRC_W-1:0]     w_acc_idx;
    logic                 w_in_wait;
    logic                 w_count;
    logic                 w_cnt_sat;
    logic                 w_mcnt_sat;
    logic                 w_sat_evt;
    logic [LAT_WIDTH-1:0] w_sample;
    logic [LAT_WIDTH-1:0] w_msample;
    logic [CW-1:0]        w_sample_ext;
    logic                 w_over_dl;
    logic [LAT_WIDTH-1:0] w_max_base;
    logic [SRC_W-1:0]     w_max_src_base;
    logic                 w_new_max;

    assign w_pend    = |irq_in;
    assign w_acc     = |irq_acc;
    assign w_in_wait = (r_state == S_WAIT);

    // Later iterations override earlier ones, so the highest set bit wins
    // when the frontend (anomalously) presents more than one acceptance.
    always_comb begin
        w_acc_idx = '0;
        for (int i = 0; i < NR_IRQ; i++) begin
            if (irq_acc[i]) begin
                w_acc_idx = SRC_W'(i);
            end
        end
    end

    // A request accepted straight out of IDLE has zero latency; otherwise the
    // running counters are the sample.
    assign w_sample     = w_in_wait ? r_cnt  : '0;
    assign w_msample    = w_in_wait ? r_mcnt : '0;
    assign w_sample_ext = CW'(w_sample);
    assign w_over_dl    = w_sample_ext > DL_C;

    // Counting cycle: still waiting, still requested, not yet accepted.
    // Saturation is an increment attempted while already at all-ones.
    assign w_count    = w_in_wait & ~w_acc & w_pend;
    assign w_cnt_sat  = w_count & (r_cnt == LAT_MAX);
    assign w_mcnt_sat = w_count & ~gie & (r_mcnt == LAT_MAX);
    assign w_sat_evt  = w_cnt_sat | w_mcnt_sat;

    // stat_clr coinciding with a record makes the record compete against
    // zero, so the max restarts from this sample alone.
    assign w_max_base     = stat_clr ? '0 : r_max_lat;
    assign w_max_src_base = stat_clr ? '0 : r_max_src;
    assign w_new_max      = w_acc & (w_sample > w_max_base);

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_mcnt          <= '0;
            r_lat_valid     <= 1'b0;
            r_last_lat      <= '0;
            r_last_masked   <= '0;
            r_last_src      <= '0;
            r_max_lat       <= '0;
            r_max_src       <= '0;
            r_deadline_miss <= 1'b0;
            r_sat_flag      <= 1'b0;
            r_drop_pulse    <= 1'b0;
        end else begin
            r_lat_valid  <= 1'b0;
            r_drop_pulse <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // An acceptance here is recorded below with sample 0 and
                    // the FSM stays put; a pending request starts counting.
                    if (!w_acc && w_pend) begin
                        r_state <= S_WAIT;
                        r_cnt   <= LAT_ONE;
                        r_mcnt  <= gie ? '0 : LAT_ONE;
                    end
                end
                S_WAIT: begin
                    if (w_acc) begin
                        r_state <= S_IDLE;
                    end else if (w_pend) begin
                        if (r_cnt != LAT_MAX) begin
                            r_cnt <= r_cnt + LAT_ONE;
                        end
                        if (!gie && (r_mcnt != LAT_MAX)) begin
                            r_mcnt <= r_mcnt + LAT_ONE;
                        end
                    end else begin
                        // Request vanished before service: no record.
                        r_state      <= S_IDLE;
                        r_drop_pulse <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_acc) begin
                r_lat_valid   <= 1'b1;
                r_last_lat    <= w_sample;
                r_last_masked <= w_msample;
                r_last_src    <= w_acc_idx;
            end

            if (w_new_max) begin
                r_max_lat <= w_sample;
                r_max_src <= w_acc_idx;
            end else begin
                r_max_lat <= w_max_base;
                r_max_src <= w_max_src_base;
            end

            r_deadline_miss <= (r_deadline_miss & ~stat_clr) | (w_acc & w_over_dl);
            r_sat_flag      <= (r_sat_flag & ~stat_clr) | w_sat_evt;
        end
    end

    assign in_wait       = w_in_wait;
    assign lat_valid     = r_lat_valid;
    assign last_lat      = r_last_lat;
    assign last_masked   = r_last_masked;
    assign last_src      = r_last_src;
    assign max_lat       = r_max_lat;
    assign max_src       = r_max_src;
    assign deadline_miss = r_deadline_miss;
    assign sat_flag      = r_sat_flag;
    assign drop_pulse    = r_drop_pulse;

endmodule

// File: doc/omsp_irq_latency_tracker.md
Name: omsp_irq_latency_tracker

Overview:
- Observer on the interrupt path. It measures, per serviced interrupt, the cycles from request to acceptance, and how many of those cycles interrupts were masked by the atomicity logic (gie low).
- Sits beside the frontend. Consumes irq lines, irq_acc and the effective gie. Drives only status/measurement outputs and never alters interrupt delivery.
- Gives hardware evidence that clix and SM-entry atomic periods keep interrupt latency within a bound.

Parameters:
NR_IRQ, 16, number of maskable interrupt lines (index NR_IRQ-1 = highest priority)
LAT_WIDTH, 16, width of all latency counters/results
DEADLINE, 1000, latency (cycles) above which deadline_miss sets

Ports:
mclk  input  1  system clock
puc_rst  input  1  reset
irq_in  input  NR_IRQ  level interrupt requests from peripherals
irq_acc  input  NR_IRQ  one-hot acceptance pulses from frontend
gie  input  1  effective interrupt enable (atomicity-monitor output)
stat_clr  input  1  single-cycle clear of max/sticky results
in_wait  output  1  a measurement is in progress
lat_valid  output  1  one-cycle pulse: last_* updated
last_lat  output  LAT_WIDTH  latency of most recent serviced request
last_masked  output  LAT_WIDTH  gie-low cycles within last_lat
last_src  output  $clog2(NR_IRQ)  index of accepted line
max_lat  output  LAT_WIDTH  largest last_lat since reset/clear
max_src  output  $clog2(NR_IRQ)  source of max_lat
deadline_miss  output  1  sticky: some latency > DEADLINE
sat_flag  output  1  sticky: a counter saturated
drop_pulse  output  1  one-cycle pulse: request withdrawn unserviced

Behaviour:
- Reset is asynchronous, active-high, on puc_rst; clock is mclk. Reset drives all outputs and internal registers to 0 and the FSM to IDLE.
- pend = |irq_in. acc = |irq_acc. acc_idx = index of the set bit of irq_acc; if more than one bit is set, the highest index wins.
- FSM states: IDLE and WAIT.
- IDLE:
  - pend & ~acc -> go to WAIT. cnt <= 1; mcnt <= (~gie ? 1 : 0).
  - pend & acc (accepted in the same cycle as first seen) -> record with sample=0, msample=0. Stay in IDLE.
  - Otherwise hold.
- WAIT:
  - ~acc & pend -> cnt <= cnt+1, saturating at all-ones. If ~gie, mcnt <= mcnt+1, also saturating. Any saturation sets sat_flag.
  - acc -> record with sample=cnt, msample=mcnt; go to IDLE.
  - ~acc & ~pend -> drop_pulse=1 for one cycle; go to IDLE; no record.
- After returning to IDLE, a still-pending line starts a new measurement on the next cycle (one-cycle gap, by design).
- Record (registered; visible on the cycle after acc):
  - last_lat<=sample, last_masked<=msample, last_src<=acc_idx, lat_valid=1 for one cycle.
  - If sample > max_lat (strict), then max_lat<=sample and max_src<=acc_idx.
  - If sample > DEADLINE, deadline_miss<=1.
- stat_clr clears max_lat, max_src, deadline_miss and sat_flag. It does not affect the FSM or the last_* outputs.
  - If stat_clr coincides with a record, the record is compared against 0, so max_lat<=sample and deadline/sat are re-evaluated from this sample only.
- in_wait = (state==WAIT), combinational from the state register.
- irq_acc arriving when pend=0 is still recorded, with sample as per the current state. This is a frontend anomaly and is not flagged.
- Unsigned arithmetic throughout; no wrap-around (counters saturate).
- puc_rst mid-WAIT aborts the measurement. No drop_pulse is generated.

Test Plan:
- irq_in[3]=1 at cycle 0 with gie=1, irq_acc[3] pulse at cycle 5 -> lat_valid at cycle 6, last_lat=5, last_masked=0, last_src=3, max_lat=5.
- gie=0 for cycles 0-39 (clix window), irq_in[7] from cycle 0, acc at 42 -> last_lat=42, last_masked=40. Then a second irq with latency 10 -> max_lat stays 42, max_src=7.
- irq_in[2] asserted at cycle 0 with irq_acc[2] pulsed in the same cycle, from IDLE -> last_lat=0, lat_valid next cycle, FSM stays IDLE.
- irq_in[1] asserted for 4 cycles and withdrawn without acc -> drop_pulse once, no lat_valid, max_lat unchanged.
- LAT_WIDTH=4 with 20-cycle wait -> last_lat=15, sat_flag=1. With DEADLINE=8 -> deadline_miss=1. stat_clr -> both clear, max_lat=0.
- stat_clr on the same cycle as acc with sample=3 and prior max_lat=50 -> max_lat=3. Separately, puc_rst mid-WAIT -> all outputs 0, FSM in IDLE.
